// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared constants and types for the pipeline control slice.
//   - FSM state encodings (plain localparam vectors, legacy-compatible)
//   - default parameter values and fixed counter widths
//   - ctrl_t: bundle of stall/flush enables, plus the canned patterns the
//     controller selects between
//   - src_hit(): one source operand vs. destination compare
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

   localparam int TIMEOUT_DEF = 16;   // MEM_WAIT cycles before memory error
   localparam int SCNT_W_DEF  = 32;   // stall-cycle counter width
   localparam int FCNT_W      = 16;   // branch-flush counter width
   localparam int WCNT_W      = 8;    // wait counter, covers TIMEOUT up to 255
   localparam int REG_W       = 5;    // register index width

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] ST_ERROR    = 2'd2;

   typedef struct packed {
      logic stall_if;
      logic stall_id;
      logic stall_ex;
      logic stall_mem;
      logic flush_id;
      logic flush_ex;
      logic flush_wb;
   } ctrl_t;

   //                                   if id ex mem fid fex fwb
   localparam ctrl_t CTRL_IDLE     = 7'b0__0__0__0___0___0___0;
   localparam ctrl_t CTRL_MEM      = 7'b1__1__1__1___0___0___1;
   localparam ctrl_t CTRL_LOAD_USE = 7'b1__1__0__0___0___1___0;
   localparam ctrl_t CTRL_BRANCH   = 7'b0__0__0__0___1___1___0;

   function automatic logic src_hit(input logic [REG_W-1:0] rs,
                                    input logic             used,
                                    input logic [REG_W-1:0] rd);
      return used && (rs == rd);
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_if
// Bundle between the pipeline datapath and the pipeline controller.
//   pipeline -> ctrl : id_rs1/2, id_rs1/2_used, ex_mem2reg, ex_reg_wena,
//                      ex_reg_waddr, ex_branch_taken, mem_req, dmem_ack
//   ctrl -> pipeline : dmem_req, stall_if/id/ex/mem, flush_id/ex/wb,
//                      mem_err, stall_cnt, flush_cnt
// Modports: master = datapath side, slave = controller side.
// ---------------------------------------------------------------------------
interface pipe_ctrl_if #(
   parameter int SCNT_W = pipe_ctrl_pkg::SCNT_W_DEF
);
   import pipe_ctrl_pkg::*;

   logic [REG_W-1:0]  id_rs1;
   logic [REG_W-1:0]  id_rs2;
   logic              id_rs1_used;
   logic              id_rs2_used;
   logic              ex_mem2reg;
   logic              ex_reg_wena;
   logic [REG_W-1:0]  ex_reg_waddr;
   logic              ex_branch_taken;
   logic              mem_req;
   logic              dmem_ack;

   logic              dmem_req;
   logic              stall_if;
   logic              stall_id;
   logic              stall_ex;
   logic              stall_mem;
   logic              flush_id;
   logic              flush_ex;
   logic              flush_wb;
   logic              mem_err;
   logic [SCNT_W-1:0] stall_cnt;
   logic [FCNT_W-1:0] flush_cnt;

   modport master (
      output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
             ex_mem2reg, ex_reg_wena, ex_reg_waddr, ex_branch_taken,
             mem_req, dmem_ack,
      input  dmem_req, stall_if, stall_id, stall_ex, stall_mem,
             flush_id, flush_ex, flush_wb, mem_err, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
             ex_mem2reg, ex_reg_wena, ex_reg_waddr, ex_branch_taken,
             mem_req, dmem_ack,
      output dmem_req, stall_if, stall_id, stall_ex, stall_mem,
             flush_id, flush_ex, flush_wb, mem_err, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Pure combinational load-use compare: the instruction in EX is a load that
// writes a non-zero register which the instruction in ID actually reads.
//   rs1, rs2           : ID source registers
//   rs1_used, rs2_used : ID source operand is really read
//   mem2reg, reg_wena  : EX instruction is a load / writes a register
//   reg_waddr          : EX destination register
//   hazard             : load-use hazard present
// ---------------------------------------------------------------------------
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] rs1,
   input  logic [REG_W-1:0] rs2,
   input  logic             rs1_used,
   input  logic             rs2_used,
   input  logic             mem2reg,
   input  logic             reg_wena,
   input  logic [REG_W-1:0] reg_waddr,
   output logic             hazard
);

   // x0 is hardwired zero, so writing it never produces a dependency
   assign hazard = mem2reg & reg_wena & (reg_waddr != '0) &
                   (src_hit(rs1, rs1_used, reg_waddr) |
                    src_hit(rs2, rs2_used, reg_waddr));

endmodule

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Pipeline stall/flush controller with data-memory wait handling.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pipe_ctrl_if.slave (see interface header for signal list)
// Parameters:
//   TIMEOUT  : max memory stall cycles before the sticky error (2..255)
//   SCNT_W   : stall counter width; must match the interface SCNT_W
// FSM RUN / MEM_WAIT / ERROR. Stall/flush/dmem_req decode combinationally
// from state and inputs; mem_err and the two counters are registered.
// ---------------------------------------------------------------------------
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int SCNT_W  = SCNT_W_DEF
) (
   input  logic          clk,
   input  logic          rst,
   pipe_ctrl_if.slave    bus
);

   // last wait_cnt value at which a missing ack still keeps waiting
   localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

   logic [1:0]        state, state_nxt;
   logic [WCNT_W-1:0] wait_cnt, wait_nxt;
   logic              mem_err;
   logic [SCNT_W-1:0] stall_cnt;
   logic [FCNT_W-1:0] flush_cnt;

   logic              hazard;
   logic              pipe_free;   // memory is not holding the pipe this cycle
   logic              br_flush;
   logic              dmem_req;
   ctrl_t             ctrl;

   hazard_detect u_hazard (
      .rs1       (bus.id_rs1),
      .rs2       (bus.id_rs2),
      .rs1_used  (bus.id_rs1_used),
      .rs2_used  (bus.id_rs2_used),
      .mem2reg   (bus.ex_mem2reg),
      .reg_wena  (bus.ex_reg_wena),
      .reg_waddr (bus.ex_reg_waddr),
      .hazard    (hazard)
   );

   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      dmem_req  = 1'b0;
      pipe_free = 1'b0;
      br_flush  = 1'b0;
      ctrl      = CTRL_IDLE;
      if (!rst) begin
         case (state)
            ST_RUN: begin
               dmem_req = bus.mem_req;
               if (bus.mem_req && !bus.dmem_ack) begin
                  ctrl      = CTRL_MEM;
                  state_nxt = ST_MEM_WAIT;
                  wait_nxt  = WCNT_W'(1);
               end else begin
                  pipe_free = 1'b1;
               end
            end
            ST_MEM_WAIT: begin
               dmem_req = 1'b1;
               if (bus.dmem_ack) begin
                  // release cycle: the pipe advances, so the frozen EX
                  // instruction is re-evaluated for branch / load-use now
                  state_nxt = ST_RUN;
                  wait_nxt  = '0;
                  pipe_free = 1'b1;
               end else begin
                  ctrl = CTRL_MEM;
                  if (wait_cnt == WAIT_LAST) state_nxt = ST_ERROR;
                  else                       wait_nxt  = wait_cnt + WCNT_W'(1);
               end
            end
            ST_ERROR: begin
               // pipe frozen for good; dmem_ack is ignored, only rst exits
               ctrl = CTRL_MEM;
            end
            default: begin
               state_nxt = ST_RUN;
               wait_nxt  = '0;
            end
         endcase

         // a taken branch discards the ID instruction, so a load-use stall
         // on it would be pointless: branch wins
         if (pipe_free) begin
            if (bus.ex_branch_taken) begin
               ctrl     = CTRL_BRANCH;
               br_flush = 1'b1;
            end else if (hazard) begin
               ctrl = CTRL_LOAD_USE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_RUN;
         wait_cnt  <= '0;
         mem_err   <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         mem_err  <= mem_err | (state_nxt == ST_ERROR);
         if (ctrl.stall_if && (stall_cnt != '1))
            stall_cnt <= stall_cnt + SCNT_W'(1);
         if (br_flush && (flush_cnt != '1))
            flush_cnt <= flush_cnt + FCNT_W'(1);
      end
   end

   assign bus.dmem_req  = dmem_req;
   assign bus.stall_if  = ctrl.stall_if;
   assign bus.stall_id  = ctrl.stall_id;
   assign bus.stall_ex  = ctrl.stall_ex;
   assign bus.stall_mem = ctrl.stall_mem;
   assign bus.flush_id  = ctrl.flush_id;
   assign bus.flush_ex  = ctrl.flush_ex;
   assign bus.flush_wb  = ctrl.flush_wb;
   assign bus.mem_err   = mem_err;
   assign bus.stall_cnt = stall_cnt;
   assign bus.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl (TIMEOUT=4, SCNT_W=4). A behavioural
// model tracks the age of the outstanding memory access, the error flag and
// the two counters; one process compares every output on each negedge.
// Directed sequences pin the model with literal expectations, then a
// randomized run exercises everything together.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

   localparam int TO   = 4;
   localparam int SW   = 4;
   localparam int SMAX = (1 << SW) - 1;
   localparam int FMAX = 65535;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   pipe_ctrl_if #(.SCNT_W(SW)) bus ();

   pipe_ctrl #(.TIMEOUT(TO), .SCNT_W(SW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int   age = 0, n_age = 0;      // cycles the current access has stalled
   bit   err = 0, n_err = 0;
   int   scnt = 0, n_scnt = 0;
   int   fcnt = 0, n_fcnt = 0;
   bit   started = 0;
   bit   lu, pend;
   logic [7:0] exp_v, act_v;      // {dmem_req, sif, sid, sex, smem, fid, fex, fwb}

   always @(negedge clk) begin
      lu = bus.ex_mem2reg && bus.ex_reg_wena && (bus.ex_reg_waddr != 0) &&
           ((bus.id_rs1_used && bus.id_rs1 == bus.ex_reg_waddr) ||
            (bus.id_rs2_used && bus.id_rs2 == bus.ex_reg_waddr));
      exp_v = 8'h00;
      n_age = age; n_err = err; n_scnt = scnt; n_fcnt = fcnt;
      if (rst) begin
         n_age = 0; n_err = 0; n_scnt = 0; n_fcnt = 0;
      end else if (err) begin
         exp_v = 8'b0111_1001;
      end else begin
         pend     = (age > 0) || bus.mem_req;
         exp_v[7] = pend;
         if (pend && !bus.dmem_ack) begin
            exp_v[6:3] = 4'hF;
            exp_v[0]   = 1'b1;
            n_age      = age + 1;
            if (n_age >= TO) n_err = 1;
         end else begin
            n_age = 0;
            if (bus.ex_branch_taken) begin
               exp_v[2] = 1'b1; exp_v[1] = 1'b1;
               n_fcnt   = (fcnt < FMAX) ? fcnt + 1 : FMAX;
            end else if (lu) begin
               exp_v[6] = 1'b1; exp_v[5] = 1'b1; exp_v[1] = 1'b1;
            end
         end
      end
      if (!rst && exp_v[6]) n_scnt = (scnt < SMAX) ? scnt + 1 : SMAX;
      if (started) begin
         act_v = {bus.dmem_req, bus.stall_if, bus.stall_id, bus.stall_ex,
                  bus.stall_mem, bus.flush_id, bus.flush_ex, bus.flush_wb};
         chk("model_ctrl", {24'd0, act_v}, {24'd0, exp_v});
         chk("model_mem_err", {31'd0, bus.mem_err}, {31'd0, err});
         chk("model_stall_cnt", {28'd0, bus.stall_cnt}, 32'(scnt));
         chk("model_flush_cnt", {16'd0, bus.flush_cnt}, 32'(fcnt));
      end
   end

   always @(posedge clk) begin
      if (rst) started = 1;
      age = n_age; err = n_err; scnt = n_scnt; fcnt = n_fcnt;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rs1_used = 0; bus.id_rs2_used = 0;
      bus.ex_mem2reg = 0; bus.ex_reg_wena = 0; bus.ex_reg_waddr = '0;
      bus.ex_branch_taken = 0; bus.mem_req = 0; bus.dmem_ack = 0;
   endtask

   task automatic load_use(input logic [4:0] r);
      bus.ex_mem2reg = 1; bus.ex_reg_wena = 1; bus.ex_reg_waddr = r;
      bus.id_rs1 = r; bus.id_rs1_used = 1;
   endtask

   initial begin
      idle();
      rst = 1;
      tick(); tick();
      @(negedge clk);
      chk("rst_dmem_req", {31'd0, bus.dmem_req}, 0);
      chk("rst_stall_cnt", {28'd0, bus.stall_cnt}, 0);
      chk("rst_mem_err", {31'd0, bus.mem_err}, 0);

      // load-use on x5, then on x0
      tick(); rst = 0; load_use(5'd5);
      @(negedge clk);
      chk("lu_stall_if", {31'd0, bus.stall_if}, 1);
      chk("lu_stall_id", {31'd0, bus.stall_id}, 1);
      chk("lu_flush_ex", {31'd0, bus.flush_ex}, 1);
      chk("lu_stall_ex", {31'd0, bus.stall_ex}, 0);
      tick(); load_use(5'd0);
      @(negedge clk);
      chk("lu_x0_stall_if", {31'd0, bus.stall_if}, 0);
      chk("lu_x0_flush_ex", {31'd0, bus.flush_ex}, 0);

      // load-use together with a taken branch
      tick(); load_use(5'd7); bus.ex_branch_taken = 1;
      @(negedge clk);
      chk("br_flush_id", {31'd0, bus.flush_id}, 1);
      chk("br_flush_ex", {31'd0, bus.flush_ex}, 1);
      chk("br_stall_if", {31'd0, bus.stall_if}, 0);
      chk("br_flush_cnt_before", {16'd0, bus.flush_cnt}, 0);
      tick(); idle();
      @(negedge clk);
      chk("br_flush_cnt_after", {16'd0, bus.flush_cnt}, 1);

      // memory access acked on its third cycle
      tick(); rst = 1;
      tick(); rst = 0; bus.mem_req = 1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("mw_stall_mem", {31'd0, bus.stall_mem}, 1);
         chk("mw_flush_wb", {31'd0, bus.flush_wb}, 1);
         tick();
      end
      bus.dmem_ack = 1;
      @(negedge clk);
      chk("mw_ack_stall_if", {31'd0, bus.stall_if}, 0);
      chk("mw_ack_flush_wb", {31'd0, bus.flush_wb}, 0);
      chk("mw_ack_dmem_req", {31'd0, bus.dmem_req}, 1);
      tick(); idle();
      @(negedge clk);
      chk("mw_stall_cnt", {28'd0, bus.stall_cnt}, 2);
      chk("mw_idle_dmem_req", {31'd0, bus.dmem_req}, 0);

      // no ack: timeout into ERROR
      tick(); bus.mem_req = 1;
      for (int i = 0; i < TO; i++) begin
         @(negedge clk);
         chk("to_stall_mem", {31'd0, bus.stall_mem}, 1);
         chk("to_mem_err_low", {31'd0, bus.mem_err}, 0);
         tick();
      end
      @(negedge clk);
      chk("err_mem_err", {31'd0, bus.mem_err}, 1);
      chk("err_dmem_req", {31'd0, bus.dmem_req}, 0);
      chk("err_stall_if", {31'd0, bus.stall_if}, 1);
      tick(); bus.dmem_ack = 1;
      @(negedge clk);
      chk("err_ack_ignored", {31'd0, bus.stall_ex}, 1);

      // reset out of ERROR
      tick(); rst = 1;
      @(negedge clk);
      chk("rst_in_err_stall_if", {31'd0, bus.stall_if}, 0);
      chk("rst_in_err_dmem_req", {31'd0, bus.dmem_req}, 0);
      tick(); rst = 0; idle();
      @(negedge clk);
      chk("post_rst_mem_err", {31'd0, bus.mem_err}, 0);
      chk("post_rst_stall_cnt", {28'd0, bus.stall_cnt}, 0);
      chk("post_rst_flush_cnt", {16'd0, bus.flush_cnt}, 0);
      chk("post_rst_stall_if", {31'd0, bus.stall_if}, 0);

      // stall counter saturation over 20 stalled cycles
      tick(); bus.mem_req = 1;
      repeat (20) tick();
      @(negedge clk);
      chk("sat_stall_cnt", {28'd0, bus.stall_cnt}, 32'hF);

      // randomized run
      tick(); rst = 1;
      tick(); rst = 0;
      for (int n = 0; n < 4000; n++) begin
         rst                 = ($urandom_range(0, 99) == 0);
         bus.id_rs1          = 5'($urandom_range(0, 3));
         bus.id_rs2          = 5'($urandom_range(0, 3));
         bus.id_rs1_used     = 1'($urandom_range(0, 1));
         bus.id_rs2_used     = 1'($urandom_range(0, 1));
         bus.ex_mem2reg      = ($urandom_range(0, 99) < 60);
         bus.ex_reg_wena     = ($urandom_range(0, 99) < 80);
         bus.ex_reg_waddr    = 5'($urandom_range(0, 3));
         bus.ex_branch_taken = ($urandom_range(0, 99) < 20);
         bus.mem_req         = ($urandom_range(0, 99) < 35);
         bus.dmem_ack        = ($urandom_range(0, 99) < 55);
         tick();
      end
      idle(); rst = 0;
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: max MEM_WAIT cycles before memory error (legal 2..255).
REQ-002 Parameter SCNT_W, default 32: stall-cycle counter width.
REQ-003 clk  in  1  sole clock, all state updates on posedge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-006 id_rs1_used, id_rs2_used  in  1 each  source operand actually read.
REQ-007 ex_mem2reg, ex_reg_wena  in  1 each  instruction in EX is a load / writes a register.
REQ-008 ex_reg_waddr  in  5  destination register of the instruction in EX.
REQ-009 ex_branch_taken  in  1  EX resolved a taken branch/jump.
REQ-010 mem_req  in  1  instruction in MEM is a load or store.
REQ-011 dmem_ack  in  1  data memory completes the access this cycle.
REQ-012 dmem_req  out  1  access request to data memory.
REQ-013 stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold PC / IF-ID / ID-EX / EX-MEM.
REQ-014 flush_id, flush_ex, flush_wb  out  1 each  load bubble into IF-ID / ID-EX / MEM-WB.
REQ-015 mem_err  out  1  sticky memory-timeout flag.
REQ-016 stall_cnt  out  SCNT_W  saturating count of cycles with stall_if=1.
REQ-017 flush_cnt  out  16  saturating count of branch-flush cycles.

Function
REQ-018 FSM states RUN, MEM_WAIT, ERROR; reset state RUN.
REQ-019 RUN: dmem_req = mem_req, combinationally.
REQ-020 RUN, mem_req=1, dmem_ack=1: no memory stall, stay RUN.
REQ-021 RUN, mem_req=1, dmem_ack=0: assert stall_if/id/ex/mem and flush_wb this cycle, next state MEM_WAIT, wait_cnt <= 1.
REQ-022 MEM_WAIT: dmem_req=1; dmem_ack=0 -> all four stalls and flush_wb asserted, wait_cnt increments.
REQ-023 MEM_WAIT, dmem_ack=1: stalls and flush_wb deasserted that same cycle, next state RUN.
REQ-024 MEM_WAIT, dmem_ack=0, wait_cnt = TIMEOUT-1: next state ERROR.
REQ-025 ERROR: mem_err=1, dmem_req=0, all stalls and flush_wb asserted; exit only via rst; dmem_ack ignored.
REQ-026 Load-use hazard = ex_mem2reg & ex_reg_wena & ex_reg_waddr!=0 & ((id_rs1_used & id_rs1==ex_reg_waddr) | (id_rs2_used & id_rs2==ex_reg_waddr)).
REQ-027 Load-use in RUN without memory stall: stall_if=1, stall_id=1, flush_ex=1 for that cycle only.
REQ-028 ex_branch_taken in RUN without memory stall: flush_id=1, flush_ex=1; overrides load-use (stall_if/stall_id forced 0).
REQ-029 Memory stall (REQ-021/022) and ERROR suppress branch and load-use outputs; EX is frozen and re-evaluated after release.
REQ-030 Register x0 never creates a hazard.
REQ-031 stall_cnt increments each cycle stall_if=1, saturates at all-ones.
REQ-032 flush_cnt increments each cycle a branch flush (REQ-028) is issued, saturates at 16'hFFFF.
REQ-033 All outputs except dmem_req, stall_*, flush_* are registered; stall_*, flush_*, dmem_req decode combinationally from state and inputs.

Reset
REQ-034 rst=1 at a posedge: state RUN, wait_cnt 0, mem_err 0, stall_cnt 0, flush_cnt 0.
REQ-035 While rst=1, dmem_req and all stall_*/flush_* outputs are 0.
REQ-036 Reset asserted in MEM_WAIT or ERROR abandons the access; no ack is awaited afterwards.

Structure
REQ-037 State encodings, TIMEOUT default and stall/flush enable constants belong in define.v alongside the existing width and enable macros.
REQ-038 One sub-module hazard_detect: pure combinational load-use compare (REQ-026, REQ-030); FSM and counters stay in pipe_ctrl.

Verification
REQ-039 ex_mem2reg=1, ex_reg_wena=1, ex_reg_waddr=5, id_rs1=5, id_rs1_used=1 -> one cycle stall_if=stall_id=flush_ex=1; same with waddr=0 -> no stall.
REQ-040 Load-use plus ex_branch_taken=1 same cycle -> flush_id=flush_ex=1, stall_if=0, flush_cnt +1.
REQ-041 mem_req=1, dmem_ack asserted on 3rd cycle -> stalls and flush_wb high exactly 2 cycles, RUN on cycle 3, stall_cnt=2.
REQ-042 mem_req=1, dmem_ack never, TIMEOUT=4 -> ERROR after 4 stall cycles, mem_err=1, dmem_req=0, stalls held.
REQ-043 rst pulsed while in ERROR -> next cycle RUN, mem_err=0, counters 0, outputs idle.
REQ-044 Force stall_cnt to all-ones (SCNT_W=4, 20 stall cycles) -> stall_cnt stays 4'hF.
